rggen_address_mapper: RTL and testbench



---
 rtl/rggen_address_mapper_pkg.sv | 28 ++
 rtl/rggen_address_window_match.sv | 24 ++
 rtl/rggen_address_mapper.sv | 169 ++++++++++++++++
 tb/tb_rggen_address_mapper.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_address_mapper_pkg.sv
// Shared encodings and helpers for the multi-window address mapper.
package rggen_address_mapper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DECODE  = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RESPOND = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'b00,
        STATUS_TIMEOUT = 2'b01,
        STATUS_SLVERR  = 2'b10,
        STATUS_DECERR  = 2'b11
    } status_e;

    // Bit of the access field that marks a write (1) versus a read (0).
    localparam int ACCESS_WRITE_BIT = 0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/rggen_address_window_match.sv
// Combinational match of one address window: range hit plus read/write permission.
module rggen_address_window_match #(
    parameter int               WIDTH     = 8,
    parameter int               LSB       = 2,
    parameter logic [WIDTH-1:0] START     = '0,
    parameter logic [31:0]      BYTE_SIZE = 32'd4,
    parameter bit               READABLE  = 1'b1,
    parameter bit               WRITABLE  = 1'b1
) (
    input  logic [WIDTH-LSB-1:0] i_word,
    input  logic                 i_write,
    output logic                 o_hit,
    output logic                 o_permit
);

    // End address truncated to WIDTH bits; a window that runs past the top does not wrap.
    localparam int               EW          = WIDTH + 32;
    localparam logic [EW-1:0]    END_FULL    = {32'd0, START} + {{WIDTH{1'b0}}, BYTE_SIZE} - EW'(1);
    localparam logic [WIDTH-1:0] END_ADDRESS = END_FULL[WIDTH-1:0];

    assign o_hit    = (i_word >= START[WIDTH-1:LSB]) && (i_word <= END_ADDRESS[WIDTH-1:LSB]);
    assign o_permit = i_write ? WRITABLE : READABLE;

endmodule

// File: rtl/rggen_address_mapper.sv
// Multi-window address mapper: accept, decode, hold one-hot select, single-cycle response.
// Optional ACCESS-state timeout enabled by defining RGGEN_ADDRESS_MAPPER_TIMEOUT_EN.
module rggen_address_mapper
    import rggen_address_mapper_pkg::*;
#(
    parameter int                       WINDOWS        = 4,
    parameter int                       WIDTH          = 8,
    parameter int                       BUS_WIDTH      = 32,
    parameter logic [WINDOWS*WIDTH-1:0] START_ADDRESS  = '0,
    parameter logic [WINDOWS*32-1:0]    BYTE_SIZE      = {WINDOWS{32'd4}},
    parameter logic [WINDOWS-1:0]       READABLE       = '1,
    parameter logic [WINDOWS-1:0]       WRITABLE       = '1,
    parameter int                       TIMEOUT_CYCLES = 255,
    localparam int                      IDX_W          = (WINDOWS > 1) ? clog2(WINDOWS) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_address,
    input  logic [1:0]         i_access,
    output logic [WINDOWS-1:0] o_select,
    output logic [IDX_W-1:0]   o_index,
    input  logic               i_target_ack,
    input  logic               i_target_error,
    output logic               o_ack,
    output logic [1:0]         o_status
);

    localparam int LSB = clog2(BUS_WIDTH) - 3;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   address_q, address_d;
    logic [1:0]         access_q, access_d;
    logic [WINDOWS-1:0] select_q, select_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [1:0]         status_q, status_d;

    logic [WINDOWS-1:0] hit, permit;
    logic               hit_any, hit_permit;
    logic [IDX_W-1:0]   hit_index;

    for (genvar g = 0; g < WINDOWS; g++) begin : g_window
        rggen_address_window_match #(
            .WIDTH     (WIDTH),
            .LSB       (LSB),
            .START     (START_ADDRESS[g*WIDTH +: WIDTH]),
            .BYTE_SIZE (BYTE_SIZE[g*32 +: 32]),
            .READABLE  (READABLE[g]),
            .WRITABLE  (WRITABLE[g])
        ) u_match (
            .i_word   (address_q[WIDTH-1:LSB]),
            .i_write  (access_q[ACCESS_WRITE_BIT]),
            .o_hit    (hit[g]),
            .o_permit (permit[g])
        );
    end

    // Scan high to low so the lowest overlapping window is the one left standing.
    always_comb begin
        hit_any    = 1'b0;
        hit_index  = '0;
        hit_permit = 1'b0;
        for (int i = WINDOWS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any    = 1'b1;
                hit_index  = IDX_W'(i);
                hit_permit = permit[i];
            end
        end
    end

    // Sub-word address bits and access bit 1 carry no decode meaning.
    logic unused_bits;
    assign unused_bits = ^{access_q[1], address_q};

`ifdef RGGEN_ADDRESS_MAPPER_TIMEOUT_EN
    localparam int TO_W = clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] count_q, count_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        access_d  = access_q;
        select_d  = select_q;
        index_d   = index_q;
        status_d  = status_q;
`ifdef RGGEN_ADDRESS_MAPPER_TIMEOUT_EN
        count_d   = count_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    address_d = i_address;
                    access_d  = i_access;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (hit_any && hit_permit) begin
                    select_d = WINDOWS'(1) << hit_index;
                    index_d  = hit_index;
                    state_d  = ST_ACCESS;
`ifdef RGGEN_ADDRESS_MAPPER_TIMEOUT_EN
                    count_d  = '0;
`endif
                end else begin
                    status_d = STATUS_DECERR;
                    state_d  = ST_RESPOND;
                end
            end
            ST_ACCESS: begin
`ifdef RGGEN_ADDRESS_MAPPER_TIMEOUT_EN
                count_d = count_q + 1'b1;
`endif
                // A target ack in the final counted cycle takes precedence over the timeout.
                if (i_target_ack) begin
                    select_d = '0;
                    status_d = i_target_error ? STATUS_SLVERR : STATUS_OK;
                    state_d  = ST_RESPOND;
                end
`ifdef RGGEN_ADDRESS_MAPPER_TIMEOUT_EN
                else if (count_d == TO_W'(TIMEOUT_CYCLES)) begin
                    select_d = '0;
                    status_d = STATUS_TIMEOUT;
                    state_d  = ST_RESPOND;
                end
`endif
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            address_q <= '0;
            access_q  <= '0;
            select_q  <= '0;
            index_q   <= '0;
            status_q  <= '0;
`ifdef RGGEN_ADDRESS_MAPPER_TIMEOUT_EN
            count_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            access_q  <= access_d;
            select_q  <= select_d;
            index_q   <= index_d;
            status_q  <= status_d;
`ifdef RGGEN_ADDRESS_MAPPER_TIMEOUT_EN
            count_q   <= count_d;
`endif
        end
    end

    assign o_ready  = (state_q == ST_IDLE);
    assign o_ack    = (state_q == ST_RESPOND);
    assign o_select = select_q;
    assign o_index  = index_q;
    assign o_status = status_q;

endmodule

// File: tb/tb_rggen_address_mapper.sv
// Directed bench: mapper A (plain windows, window 0 read-only) and B (overlap, window 3 write-only).
module tb_rggen_address_mapper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n   = 1'b1;
    logic       valid   = 1'b0;
    logic [7:0] address = '0;
    logic [1:0] access  = '0;
    logic       tack    = 1'b0;
    logic       terr    = 1'b0;
    logic       dsel    = 1'b0;

    logic       a_ready, b_ready, a_ack, b_ack;
    logic [3:0] a_select, b_select;
    logic [1:0] a_index, b_index, a_status, b_status;

    int checks   = 0;
    int failures = 0;

    wire       ready  = dsel ? b_ready  : a_ready;
    wire       ack    = dsel ? b_ack    : a_ack;
    wire [3:0] sel    = dsel ? b_select : a_select;
    wire [1:0] index  = dsel ? b_index  : a_index;
    wire [1:0] status = dsel ? b_status : a_status;

    rggen_address_mapper #(
        .START_ADDRESS  ({8'h0C, 8'h08, 8'h04, 8'h00}),
        .WRITABLE       (4'b1110),
        .TIMEOUT_CYCLES (5)
    ) dut_a (
        .i_clk (clk), .i_rst_n (rst_n),
        .i_valid (valid & ~dsel), .o_ready (a_ready),
        .i_address (address), .i_access (access),
        .o_select (a_select), .o_index (a_index),
        .i_target_ack (tack & ~dsel), .i_target_error (terr),
        .o_ack (a_ack), .o_status (a_status)
    );

    rggen_address_mapper #(
        .START_ADDRESS ({8'h0C, 8'h08, 8'h04, 8'h00}),
        .BYTE_SIZE     ({32'd4, 32'd4, 32'd8, 32'd4}),
        .READABLE      (4'b0111)
    ) dut_b (
        .i_clk (clk), .i_rst_n (rst_n),
        .i_valid (valid & dsel), .o_ready (b_ready),
        .i_address (address), .i_access (access),
        .o_select (b_select), .o_index (b_index),
        .i_target_ack (tack & dsel), .i_target_error (terr),
        .o_ack (b_ack), .o_status (b_status)
    );

    // Presents one request for one cycle, then scrambles the inputs; returns at the
    // negedge of the DECODE cycle (accept cycle T + 1).
    task automatic start_req(input logic which, input logic [7:0] a, input logic [1:0] acc);
        @(negedge clk);
        dsel = which; valid = 1'b1; address = a; access = acc;
        @(negedge clk);
        valid = 1'b0; address = 8'hFF; access = ~acc;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_ready, a_select, a_index, a_ack, a_status} !== {1'b1, 4'b0, 2'd0, 1'b0, 2'b00}) begin
            failures++;
            $display("FAIL reset_a got rdy=%b sel=%b idx=%0d ack=%b st=%b", a_ready, a_select, a_index, a_ack, a_status);
        end
        checks++;
        if ({b_ready, b_select, b_ack} !== {1'b1, 4'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_b got rdy=%b sel=%b ack=%b", b_ready, b_select, b_ack);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_hit();
        start_req(1'b0, 8'h08, 2'b00);
        checks++;
        if ({ready, sel} !== 5'b0) begin
            failures++; $display("FAIL hit_decode got rdy=%b sel=%b exp 0/0000", ready, sel);
        end
        @(negedge clk);
        checks++;
        if ({sel, index, ack} !== {4'b0100, 2'd2, 1'b0}) begin
            failures++; $display("FAIL hit_select got sel=%b idx=%0d ack=%b exp 0100/2/0", sel, index, ack);
        end
        @(negedge clk);
        @(negedge clk);
        tack = 1'b1;
        checks++;
        if ({sel, ack} !== {4'b0100, 1'b0}) begin
            failures++; $display("FAIL hit_hold got sel=%b ack=%b exp 0100/0", sel, ack);
        end
        @(negedge clk);
        tack = 1'b0;
        checks++;
        if ({ack, status, sel} !== {1'b1, 2'b00, 4'b0}) begin
            failures++; $display("FAIL hit_resp got ack=%b st=%b sel=%b exp 1/00/0000", ack, status, sel);
        end
        @(negedge clk);
        checks++;
        if ({ack, ready} !== 2'b01) begin
            failures++; $display("FAIL hit_idle got ack=%b rdy=%b exp 0/1", ack, ready);
        end
        // Sub-word bits ignored; ack on the first ACCESS cycle gives the minimum latency.
        start_req(1'b0, 8'h0B, 2'b00);
        @(negedge clk);
        tack = 1'b1;
        checks++;
        if ({sel, index} !== {4'b0100, 2'd2}) begin
            failures++; $display("FAIL lowbits_sel got sel=%b idx=%0d exp 0100/2", sel, index);
        end
        @(negedge clk);
        tack = 1'b0;
        checks++;
        if ({ack, status} !== {1'b1, 2'b00}) begin
            failures++; $display("FAIL min_latency got ack=%b st=%b exp 1/00", ack, status);
        end
        @(negedge clk);
    endtask

    task automatic test_decerr();
        start_req(1'b0, 8'h20, 2'b00);
        checks++;
        if ({ready, ack} !== 2'b00) begin
            failures++; $display("FAIL decerr_decode got rdy=%b ack=%b exp 0/0", ready, ack);
        end
        @(negedge clk);
        checks++;
        if ({ack, status, sel} !== {1'b1, 2'b11, 4'b0}) begin
            failures++; $display("FAIL decerr_resp got ack=%b st=%b sel=%b exp 1/11/0000", ack, status, sel);
        end
        @(negedge clk);
        tack = 1'b1;
        checks++;
        if ({ack, ready} !== 2'b01) begin
            failures++; $display("FAIL decerr_idle got ack=%b rdy=%b exp 0/1", ack, ready);
        end
        @(negedge clk);
        tack = 1'b0;
        checks++;
        if ({ack, status, ready} !== {1'b0, 2'b11, 1'b1}) begin
            failures++; $display("FAIL idle_ack_ignored got ack=%b st=%b rdy=%b exp 0/11/1", ack, status, ready);
        end
        start_req(1'b0, 8'h10, 2'b00);
        @(negedge clk);
        checks++;
        if ({ack, status, sel} !== {1'b1, 2'b11, 4'b0}) begin
            failures++; $display("FAIL past_top got ack=%b st=%b sel=%b exp 1/11/0000", ack, status, sel);
        end
        @(negedge clk);
    endtask

    task automatic test_write_perm();
        start_req(1'b0, 8'h00, 2'b01);
        @(negedge clk);
        checks++;
        if ({ack, status, sel} !== {1'b1, 2'b11, 4'b0}) begin
            failures++; $display("FAIL wr_readonly got ack=%b st=%b sel=%b exp 1/11/0000", ack, status, sel);
        end
        @(negedge clk);
        start_req(1'b0, 8'h00, 2'b00);
        tack = 1'b1;
        @(negedge clk);
        tack = 1'b0;
        checks++;
        if ({sel, index, ack} !== {4'b0001, 2'd0, 1'b0}) begin
            failures++; $display("FAIL rd_window0 got sel=%b idx=%0d ack=%b exp 0001/0/0", sel, index, ack);
        end
        @(negedge clk);
        tack = 1'b1;
        checks++;
        if ({sel, ack} !== {4'b0001, 1'b0}) begin
            failures++; $display("FAIL decode_ack_ignored got sel=%b ack=%b exp 0001/0", sel, ack);
        end
        @(negedge clk);
        tack = 1'b0;
        checks++;
        if ({ack, status, sel} !== {1'b1, 2'b00, 4'b0}) begin
            failures++; $display("FAIL rd_window0_resp got ack=%b st=%b sel=%b exp 1/00/0000", ack, status, sel);
        end
        @(negedge clk);
    endtask

    task automatic test_overlap();
        start_req(1'b1, 8'h08, 2'b00);
        @(negedge clk);
        tack = 1'b1; terr = 1'b1;
        checks++;
        if ({sel, index} !== {4'b0010, 2'd1}) begin
            failures++; $display("FAIL overlap_sel got sel=%b idx=%0d exp 0010/1", sel, index);
        end
        @(negedge clk);
        tack = 1'b0; terr = 1'b0;
        checks++;
        if ({ack, status, sel} !== {1'b1, 2'b10, 4'b0}) begin
            failures++; $display("FAIL slverr got ack=%b st=%b sel=%b exp 1/10/0000", ack, status, sel);
        end
        @(negedge clk);
        start_req(1'b1, 8'h0C, 2'b00);
        @(negedge clk);
        checks++;
        if ({ack, status, sel} !== {1'b1, 2'b11, 4'b0}) begin
            failures++; $display("FAIL rd_writeonly got ack=%b st=%b sel=%b exp 1/11/0000", ack, status, sel);
        end
        @(negedge clk);
        start_req(1'b1, 8'h0C, 2'b01);
        @(negedge clk);
        tack = 1'b1;
        checks++;
        if ({sel, index} !== {4'b1000, 2'd3}) begin
            failures++; $display("FAIL wr_window3 got sel=%b idx=%0d exp 1000/3", sel, index);
        end
        @(negedge clk);
        tack = 1'b0;
        checks++;
        if ({ack, status} !== {1'b1, 2'b00}) begin
            failures++; $display("FAIL wr_window3_resp got ack=%b st=%b exp 1/00", ack, status);
        end
        @(negedge clk);
        dsel = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0] acks, rdys;
        dsel = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) begin valid = 1'b1; address = 8'h40; access = 2'b00; end
            acks[c] = ack;
            rdys[c] = ready;
        end
        valid = 1'b0;
        checks++;
        if ({acks, rdys} !== {6'b100100, 6'b001001}) begin
            failures++; $display("FAIL back_to_back got ack=%b rdy=%b exp 100100/001001", acks, rdys);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic seen;
        start_req(1'b0, 8'h04, 2'b00);
        @(negedge clk);
        checks++;
        if (sel !== 4'b0010) begin
            failures++; $display("FAIL pre_reset_sel got sel=%b exp 0010", sel);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tack = 1'b1;
        checks++;
        if ({sel, ready, ack, index, status} !== {4'b0, 1'b1, 1'b0, 2'd0, 2'b00}) begin
            failures++;
            $display("FAIL mid_reset got sel=%b rdy=%b ack=%b idx=%0d st=%b", sel, ready, ack, index, status);
        end
        @(negedge clk);
        rst_n = 1'b1; tack = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ack !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++; $display("FAIL aborted_ack got ack=1 exp none");
        end
        start_req(1'b0, 8'h0C, 2'b00);
        @(negedge clk);
        tack = 1'b1;
        checks++;
        if ({sel, index} !== {4'b1000, 2'd3}) begin
            failures++; $display("FAIL post_reset_sel got sel=%b idx=%0d exp 1000/3", sel, index);
        end
        @(negedge clk);
        tack = 1'b0;
        checks++;
        if ({ack, status} !== {1'b1, 2'b00}) begin
            failures++; $display("FAIL post_reset_resp got ack=%b st=%b exp 1/00", ack, status);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic held;
`ifdef RGGEN_ADDRESS_MAPPER_TIMEOUT_EN
        for (int rep = 0; rep < 2; rep++) begin
            start_req(1'b0, 8'h04, 2'b00);
            held = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if ({sel, ack} !== {4'b0010, 1'b0}) held = 1'b0;
                if (rep == 1 && c == 4) tack = 1'b1;
            end
            checks++;
            if (!held) begin
                failures++; $display("FAIL timeout_hold rep=%0d got sel=%b ack=%b exp 0010/0", rep, sel, ack);
            end
            @(negedge clk);
            tack = 1'b0;
            checks++;
            if ({ack, status, sel} !== {1'b1, (rep == 0) ? 2'b01 : 2'b00, 4'b0}) begin
                failures++; $display("FAIL timeout_resp rep=%0d got ack=%b st=%b sel=%b", rep, ack, status, sel);
            end
            @(negedge clk);
        end
`else
        start_req(1'b0, 8'h04, 2'b00);
        held = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ({sel, ack} !== {4'b0010, 1'b0}) held = 1'b0;
        end
        tack = 1'b1;
        checks++;
        if (!held) begin
            failures++; $display("FAIL no_timeout_hold got sel=%b ack=%b exp 0010/0", sel, ack);
        end
        @(negedge clk);
        tack = 1'b0;
        checks++;
        if ({ack, status, sel} !== {1'b1, 2'b00, 4'b0}) begin
            failures++; $display("FAIL late_ack_resp got ack=%b st=%b sel=%b exp 1/00/0000", ack, status, sel);
        end
        @(negedge clk);
`endif
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_decerr();
        test_write_perm();
        test_overlap();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
